// File: rtl/uart_xcvr.sv
// uart_xcvr: UART transceiver with a TX FIFO and an optional RX path.
// The RX path is built only when UART_XCVR_RX_EN is defined. Without it,
// rx and re are ignored, and empty=1, rdata=0, rx_err=0 are constant.
//
// Frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
// Every bit lasts DIV = CLK_HZ/BAUD clock cycles.
//
// Ports
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   wdata   in   [31:0] TX word; only [DATA_BITS-1:0] is sent
//   we      in   TX FIFO push strobe (ignored while full, unless a pop frees a slot)
//   full    out  TX FIFO holds TX_DEPTH words
//   re      in   RX FIFO pop strobe
//   rdata   out  [31:0] RX FIFO head, zero-extended; 0 when empty
//   empty   out  RX FIFO holds no words
//   rx_err  out  sticky overrun / framing error, cleared by a successful pop
//   tx      out  serial output, idles high
//   rx      in   asynchronous serial input
module uart_xcvr #(
  parameter int CLK_HZ    = 25000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic        full,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        empty,
  output logic        rx_err,
  output logic        tx,
  input  logic        rx
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV) + 1;
  localparam int TAW   = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // TX FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TAW:0]         tx_wp, tx_rp;
  logic                 tx_fifo_empty, tx_push, tx_pop;

  // TX FSM state
  state_t               tx_state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [3:0]           tx_bitc;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_r;

  assign tx_fifo_empty = (tx_wp == tx_rp);
  assign full    = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  // Pop in IDLE, or at the end of STOP so the next frame follows with no gap
  assign tx_pop  = !tx_fifo_empty &&
                   ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == DIV_LAST));
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted
  assign tx_push = we && (!full || tx_pop);
  assign tx      = tx_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[DATA_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bitc  <= '0;
      tx_r     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_sh    <= tx_mem[tx_rp[TAW-1:0]];
            tx_r     <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bitc  <= '0;
            tx_r     <= tx_sh[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bitc == BIT_LAST) begin
              tx_r     <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_r    <= tx_sh[1];
              tx_sh   <= tx_sh >> 1;
              tx_bitc <= tx_bitc + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_sh    <= tx_mem[tx_rp[TAW-1:0]];
              tx_r     <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_XCVR_RX_EN
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  logic                 rx_s1, rx_s2, rx_prev;
  state_t               rx_state;
  logic [CNT_W-1:0]     rx_cnt;
  logic [3:0]           rx_bitc;
  logic [DATA_BITS-1:0] rx_sh;
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]         rx_wp, rx_rp;
  logic                 rx_fifo_empty, rx_full, rx_push, rx_pop;
  logic                 stop_smp, set_err, rx_err_r;

  assign rx_fifo_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign stop_smp = (rx_state == S_STOP) && (rx_cnt == DIV_LAST);
  assign rx_push  = stop_smp && rx_s2 && !rx_full;
  // Framing error (stop sampled low) or overrun (good word, FIFO full)
  assign set_err  = stop_smp && (!rx_s2 || rx_full);
  assign rx_pop   = re && !rx_fifo_empty;

  assign empty  = rx_fifo_empty;
  assign rdata  = rx_fifo_empty ? 32'd0
                                : {{(32-DATA_BITS){1'b0}}, rx_mem[rx_rp[RAW-1:0]]};
  assign rx_err = rx_err_r;

  // RX FSM; after a framing error the FSM waits in IDLE for a fresh
  // high-to-low transition, so a line held low cannot restart a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bitc  <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bitc  <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
            if (rx_bitc == BIT_LAST) rx_state <= S_STOP;
            else                     rx_bitc  <= rx_bitc + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_err_r <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (set_err)     rx_err_r <= 1'b1;
      else if (rx_pop) rx_err_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
  end

  logic unused_in;
  assign unused_in = ^wdata[31:DATA_BITS];
`else
  assign empty  = 1'b1;
  assign rdata  = 32'd0;
  assign rx_err = 1'b0;

  logic unused_in;
  assign unused_in = ^{wdata[31:DATA_BITS], re, rx, RX_DEPTH[0], HALF[0]};
`endif

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, legal 5..8, payload bits per frame.
REQ-004 Parameter TX_DEPTH, default 16, power of two >= 2, TX FIFO entries.
REQ-005 Parameter RX_DEPTH, default 16, power of two >= 2, RX FIFO entries.
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 wdata  in  32  TX write data; only bits [DATA_BITS-1:0] are used.
REQ-009 we  in  1  TX FIFO push strobe, one word per cycle.
REQ-010 full  out  1  TX FIFO holds TX_DEPTH words.
REQ-011 re  in  1  RX FIFO pop strobe.
REQ-012 rdata  out  32  RX FIFO head word, zero-extended from DATA_BITS.
REQ-013 empty  out  1  RX FIFO holds no words.
REQ-014 rx_err  out  1  sticky error flag: overrun or framing error.
REQ-015 tx  out  1  serial output; idles high.
REQ-016 rx  in  1  asynchronous serial input.

Function
REQ-017 Bit period DIV SHALL be CLK_HZ/BAUD, integer-truncated; every bit lasts exactly DIV cycles.
REQ-018 Frame SHALL be 1 start (0), DATA_BITS data LSB first, 1 stop (1); no parity.
REQ-019 we with full=0 SHALL push wdata; we with full=1 SHALL be ignored (word dropped, FIFO unchanged).
REQ-020 TX FSM states IDLE, START, DATA, STOP; in IDLE with FIFO non-empty it SHALL pop the head and enter START.
REQ-021 On a write to an empty FIFO with FSM in IDLE, tx SHALL fall no later than 2 cycles after the we cycle.
REQ-022 After STOP completes, the next queued word SHALL start immediately (back-to-back frames, no extra idle).
REQ-023 Simultaneous push and pop on a full TX FIFO SHALL accept the push (pop frees the slot in the same cycle).
REQ-024 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-025 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronised falling edge.
REQ-026 START SHALL resample at DIV/2 cycles; if high, return to IDLE (glitch rejection, no error).
REQ-027 Data bits and stop bit SHALL be sampled at DIV-cycle intervals from the start-bit midpoint.
REQ-028 Stop bit sampled 0 SHALL discard the word, set rx_err, and return to IDLE after rx goes high.
REQ-029 Valid word with RX FIFO full SHALL be discarded and set rx_err; FIFO contents unchanged.
REQ-030 rdata SHALL be first-word-fall-through: valid whenever empty=0; re pops, next word visible next cycle.
REQ-031 re with empty=1 SHALL be ignored; rdata then 0.
REQ-032 rx_err SHALL clear on any cycle with re=1 and empty=0, unless a new error is flagged that same cycle (set wins).
REQ-033 Pointer wrap-around SHALL use log2(depth)+1-bit pointers; full/empty derived from pointer compare only.

Reset
REQ-034 rst SHALL flush both FIFOs, return both FSMs to IDLE, and clear bit/cycle counters.
REQ-035 During and after rst: tx=1, full=0, empty=1, rdata=0, rx_err=0.
REQ-036 rst mid-frame SHALL abort the TX frame (tx high next cycle) and drop any partial RX word.

Configuration
REQ-037 Macro UART_XCVR_RX_EN: defined -> full RX path (REQ-024..033) built.
REQ-038 Without UART_XCVR_RX_EN: no RX logic, rx ignored, empty=1, rdata=0, rx_err=0 constant; TX unchanged.

Verification (CLK_HZ=16, BAUD=1, so DIV=16; DATA_BITS=8)
REQ-039 we with wdata=32'h000000A5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles, then idle high.
REQ-040 Write 17 words to TX_DEPTH=16 while FSM busy -> full=1 after 16 stored words; 17th dropped; exactly 16 frames transmitted.
REQ-041 Drive rx frame for 8'h3C -> empty=0, rdata=32'h0000003C; re -> empty=1 next cycle.
REQ-042 rx low pulse of 4 cycles -> no word, rx_err=0; frame 8'h55 with stop bit 0 -> no word, rx_err=1.
REQ-043 Send 17 frames with RX_DEPTH=16 and no re -> rx_err=1, first 16 words retained in order; one re clears rx_err.
REQ-044 Assert rst during DATA of a TX frame -> tx=1 next cycle, full=0; FIFO empty, no further frames.
